// File: rtl/arith_encoder_pkg.sv
// Shared constants, the stage-1 register layout and the min-prob term
// table contents for the od_ec style multi-symbol arithmetic encoder.
// No ports; imported by arithmetic_encoder and arith_renorm.
package arith_encoder_pkg;

    localparam int GENERAL_RANGE_WIDTH    = 16;
    localparam int GENERAL_LOW_WIDTH      = 24;
    localparam int GENERAL_SYMBOL_WIDTH   = 4;
    localparam int GENERAL_LUT_ADDR_WIDTH = 8;
    localparam int GENERAL_LUT_DATA_WIDTH = 16;
    localparam int GENERAL_D_SIZE         = 4;

    localparam int EC_PROB_SHIFT = 6;
    localparam int EC_MIN_PROB   = 4;
    localparam int CDF_PROB_TOP  = 32768;

    // One spare bit above low so the carry out of low + (rng - u) survives
    // until the flush mask decides whether it is kept.
    localparam int LOW_SUM_WIDTH = GENERAL_LOW_WIDTH + 1;
    localparam int CNT_WIDTH     = 6;
    localparam int LUT_DEPTH     = 1 << GENERAL_LUT_ADDR_WIDTH;
    localparam int PROB_WIDTH    = GENERAL_RANGE_WIDTH - EC_PROB_SHIFT;

    localparam logic [GENERAL_RANGE_WIDTH-1:0] RANGE_RESET = 16'h8000;
    localparam logic signed [CNT_WIDTH-1:0]    CNT_RESET   = -6'sd9;

    typedef struct packed {
        logic [PROB_WIDTH-1:0]             a;     // fl >> 6
        logic [PROB_WIDTH-1:0]             b;     // fh >> 6
        logic                              flag;  // fl < 32768 (symbol is not the first)
        logic [GENERAL_LUT_DATA_WIDTH-1:0] tu;    // 4*(N-(s-1))
        logic [GENERAL_LUT_DATA_WIDTH-1:0] tv;    // 4*(N-s)
        logic                              valid;
    } stage1_t;

    // Table entry at address {N, k} is 4*(N-k). Entries with k > N are
    // never addressed by a legal symbol and simply wrap.
    function automatic logic [GENERAL_LUT_DATA_WIDTH-1:0] min_prob_term(
        input logic [GENERAL_LUT_ADDR_WIDTH-1:0] addr
    );
        return GENERAL_LUT_DATA_WIDTH'(EC_MIN_PROB * (int'(addr[7:4]) - int'(addr[3:0])));
    endfunction

endpackage

// File: rtl/arith_renorm.sv
// Combinational renormalization for the arithmetic encoder.
// Ports:
//   r_in     new range before normalization (never zero)
//   low_in   new low before flush masking (one carry bit above LOW_WIDTH)
//   cnt_in   signed bit counter of the coder
//   rng_out  range shifted so its MSB is set
//   low_out  low after flush masking and the same shift, truncated
//   cnt_out  updated signed bit counter
module arith_renorm
    import arith_encoder_pkg::*;
(
    input  logic [GENERAL_RANGE_WIDTH-1:0]  r_in,
    input  logic [LOW_SUM_WIDTH-1:0]        low_in,
    input  logic signed [CNT_WIDTH-1:0]     cnt_in,
    output logic [GENERAL_RANGE_WIDTH-1:0]  rng_out,
    output logic [GENERAL_LOW_WIDTH-1:0]    low_out,
    output logic signed [CNT_WIDTH-1:0]     cnt_out
);

    logic [GENERAL_D_SIZE-1:0]    d;
    logic signed [CNT_WIDTH-1:0]  d_s;
    logic signed [CNT_WIDTH-1:0]  s2;
    logic signed [CNT_WIDTH-1:0]  c;
    logic [LOW_SUM_WIDTH-1:0]     mask;
    logic [LOW_SUM_WIDTH-1:0]     low_m;

    // Leading-zero count: the highest set bit is visited last and wins.
    always_comb begin
        d = 4'd15;
        for (int i = 0; i < GENERAL_RANGE_WIDTH; i++) begin
            if (r_in[i]) begin
                d = 4'(15 - i);
            end
        end
    end

    // When the counter crosses zero, one or two bytes would leave the
    // coder; they are dropped here and only their bits are cleared from low.
    always_comb begin
        d_s     = $signed({2'b00, d});
        s2      = cnt_in + d_s;
        c       = cnt_in + 6'sd16;
        mask    = '1;
        low_m   = low_in;
        cnt_out = s2;
        if (s2 >= 0) begin
            mask = (LOW_SUM_WIDTH'(1) << c) - LOW_SUM_WIDTH'(1);
            if (s2 >= 6'sd8) begin
                low_m = low_m & mask;
                c     = c - 6'sd8;
                mask  = mask >> 8;
            end
            cnt_out = c + d_s - 6'sd24;
            low_m   = low_m & mask;
        end
        rng_out = r_in << d;
        low_out = GENERAL_LOW_WIDTH'(low_m << d);
    end

endmodule

// File: rtl/arithmetic_encoder.sv
// Three-stage od_ec (Q15 inverse CDF) multi-symbol arithmetic encoder core.
// Stage 1 registers the scaled CDF bounds and min-prob terms, stage 2 is
// the single-cycle rng/low/cnt update loop, stage 3 registers the outputs.
// Ports:
//   general_clk     clock, rising edge
//   reset           asynchronous active-high reset
//   general_fl      icdf[s-1] (32768 for s = 0)
//   general_fh      icdf[s]
//   general_symbol  symbol index s
//   general_nsyms   alphabet size (N = nsyms - 1)
//   RANGE_OUTPUT    registered range after renormalization
//   LOW_OUTPUT      registered low after flush masking and shift
module arithmetic_encoder
    import arith_encoder_pkg::*;
(
    input  logic                              general_clk,
    input  logic                              reset,
    input  logic [GENERAL_RANGE_WIDTH-1:0]    general_fl,
    input  logic [GENERAL_RANGE_WIDTH-1:0]    general_fh,
    input  logic [GENERAL_SYMBOL_WIDTH-1:0]   general_symbol,
    input  logic [GENERAL_SYMBOL_WIDTH:0]     general_nsyms,
    output logic [GENERAL_RANGE_WIDTH-1:0]    RANGE_OUTPUT,
    output logic [GENERAL_LOW_WIDTH-1:0]      LOW_OUTPUT
);

    logic [GENERAL_LUT_DATA_WIDTH-1:0] min_prob_rom [LUT_DEPTH];

    for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_rom
        assign min_prob_rom[gi] = min_prob_term(GENERAL_LUT_ADDR_WIDTH'(gi));
    end

    stage1_t                           stage1_d, stage1_q;
    logic [GENERAL_SYMBOL_WIDTH-1:0]   n_sym;
    logic [GENERAL_LUT_ADDR_WIDTH-1:0] tu_addr, tv_addr;

    logic [GENERAL_RANGE_WIDTH-1:0]    rng_d, rng_q;
    logic [GENERAL_LOW_WIDTH-1:0]      low_d, low_q;
    logic signed [CNT_WIDTH-1:0]       cnt_d, cnt_q;
    logic [GENERAL_RANGE_WIDTH-1:0]    range_out_d, range_out_q;
    logic [GENERAL_LOW_WIDTH-1:0]      low_out_d, low_out_q;

    logic [7:0]                        q_val;
    logic [17:0]                       prod_a, prod_b, u_val, v_val;
    logic [LOW_SUM_WIDTH-1:0]          low_sum;
    logic [GENERAL_RANGE_WIDTH-1:0]    r_new, rng_norm;
    logic [GENERAL_LOW_WIDTH-1:0]      low_norm;
    logic signed [CNT_WIDTH-1:0]       cnt_norm;

    // TU is fetched from {N, s-1}, which holds 4*(N-(s-1)). For s = 0 the
    // address wraps, but TU is only used when fl < 32768, i.e. s > 0. TV
    // comes from {N, s}, so s = N correctly yields 0 without wrapping.
    always_comb begin
        n_sym           = 4'(general_nsyms - 5'd1);
        tu_addr         = {n_sym, 4'(general_symbol - 4'd1)};
        tv_addr         = {n_sym, general_symbol};
        stage1_d        = '0;
        stage1_d.a      = PROB_WIDTH'(general_fl >> EC_PROB_SHIFT);
        stage1_d.b      = PROB_WIDTH'(general_fh >> EC_PROB_SHIFT);
        stage1_d.flag   = (general_fl < 16'(CDF_PROB_TOP));
        stage1_d.tu     = min_prob_rom[tu_addr];
        stage1_d.tv     = min_prob_rom[tv_addr];
        stage1_d.valid  = 1'b1;
    end

    always_comb begin
        q_val  = rng_q[15:8];
        prod_a = 18'(q_val) * 18'(stage1_q.a);
        prod_b = 18'(q_val) * 18'(stage1_q.b);
        u_val  = (prod_a >> 1) + 18'(stage1_q.tu);
        v_val  = (prod_b >> 1) + 18'(stage1_q.tv);
        if (stage1_q.flag) begin
            low_sum = LOW_SUM_WIDTH'(low_q) + LOW_SUM_WIDTH'(rng_q) - LOW_SUM_WIDTH'(u_val);
            r_new   = 16'(u_val - v_val);
        end else begin
            low_sum = LOW_SUM_WIDTH'(low_q);
            r_new   = 16'(18'(rng_q) - v_val);
        end
    end

    arith_renorm u_renorm (
        .r_in    (r_new),
        .low_in  (low_sum),
        .cnt_in  (cnt_q),
        .rng_out (rng_norm),
        .low_out (low_norm),
        .cnt_out (cnt_norm)
    );

    always_comb begin
        rng_d = rng_q;
        low_d = low_q;
        cnt_d = cnt_q;
        if (stage1_q.valid) begin
            rng_d = rng_norm;
            low_d = low_norm;
            cnt_d = cnt_norm;
        end
        range_out_d = rng_q;
        low_out_d   = low_q;
    end

    always_ff @(posedge general_clk or posedge reset) begin
        if (reset) begin
            stage1_q    <= '0;
            rng_q       <= RANGE_RESET;
            low_q       <= '0;
            cnt_q       <= CNT_RESET;
            range_out_q <= RANGE_RESET;
            low_out_q   <= '0;
        end else begin
            stage1_q    <= stage1_d;
            rng_q       <= rng_d;
            low_q       <= low_d;
            cnt_q       <= cnt_d;
            range_out_q <= range_out_d;
            low_out_q   <= low_out_d;
        end
    end

    assign RANGE_OUTPUT = range_out_q;
    assign LOW_OUTPUT   = low_out_q;

endmodule

// File: tb/tb_arithmetic_encoder.sv
module tb_arithmetic_encoder;

    logic        general_clk = 1'b0;
    logic        reset;
    logic [15:0] general_fl;
    logic [15:0] general_fh;
    logic [3:0]  general_symbol;
    logic [4:0]  general_nsyms;
    logic [15:0] RANGE_OUTPUT;
    logic [23:0] LOW_OUTPUT;

    always #5 general_clk = ~general_clk;

    arithmetic_encoder dut (
        .general_clk    (general_clk),
        .reset          (reset),
        .general_fl     (general_fl),
        .general_fh     (general_fh),
        .general_symbol (general_symbol),
        .general_nsyms  (general_nsyms),
        .RANGE_OUTPUT   (RANGE_OUTPUT),
        .LOW_OUTPUT     (LOW_OUTPUT)
    );

    typedef struct {
        longint rng;
        longint low;
        string  name;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     total = 0;
    int     bad   = 0;
    logic   drive_chk = 1'b0;
    logic [2:0] chk_pipe;

    longint m_rng, m_low;
    int     m_cnt;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: od_ec_encode_q15 followed by od_ec_enc_normalize.
    task automatic model_step(input int fl, input int fh, input int s, input int ns);
        longint q, u, v, r, l, msk;
        int     d, c, s2, n;
        n = ns - 1;
        q = m_rng >> 8;
        v = ((q * longint'(fh >> 6)) >> 1) + 4 * (n - s);
        if (fl < 32768) begin
            u = ((q * longint'(fl >> 6)) >> 1) + 4 * (n - (s - 1));
            l = m_low + (m_rng - u);
            r = u - v;
        end else begin
            l = m_low;
            r = m_rng - v;
        end
        d = 0;
        while (((r << d) & 64'h8000) == 0 && d < 15) d++;
        c  = m_cnt;
        s2 = c + d;
        if (s2 >= 0) begin
            c   = c + 16;
            msk = (longint'(1) << c) - 1;
            if (s2 >= 8) begin
                l   = l & msk;
                c   = c - 8;
                msk = msk >> 8;
            end
            s2 = c + d - 24;
            l  = l & msk;
        end
        m_rng = (r << d) & 64'hFFFF;
        m_low = (l << d) & 64'hFFFFFF;
        m_cnt = s2;
    endtask

    // Expected outputs become due two edges after the sampling edge.
    always @(posedge general_clk or posedge reset) begin
        if (reset) chk_pipe <= 3'b000;
        else       chk_pipe <= {chk_pipe[1:0], drive_chk};
    end

    always @(negedge general_clk) begin
        if (!reset && chk_pipe[2]) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output actual=rng %0d required=no pending entry", RANGE_OUTPUT);
            end else begin
                mon_e = exp_q.pop_front();
                $display("txn %s rng=%0d low=%0d exp_rng=%0d exp_low=%0d",
                         mon_e.name, RANGE_OUTPUT, LOW_OUTPUT, mon_e.rng, mon_e.low);
                check({mon_e.name, "_rng"}, longint'(RANGE_OUTPUT), mon_e.rng);
                check({mon_e.name, "_low"}, longint'(LOW_OUTPUT), mon_e.low);
            end
        end
    end

    task automatic drive(input int fl, input int fh, input int s, input int ns);
        general_fl     = 16'(fl);
        general_fh     = 16'(fh);
        general_symbol = 4'(s);
        general_nsyms  = 5'(ns);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        drive_chk = 1'b0;
        drive(32768, 16384, 0, 2);
        exp_q.delete();
        m_rng = 32768;
        m_low = 0;
        m_cnt = -9;
        repeat (2) @(negedge general_clk);
    endtask

    // Drives one symbol for one clock and queues its expected outputs,
    // either the hand-computed pair or the reference model result.
    task automatic issue(input int fl, input int fh, input int s, input int ns,
                         input bit use_model, input longint hr, input longint hl,
                         input string name);
        exp_t e;
        drive(fl, fh, s, ns);
        model_step(fl, fh, s, ns);
        e.rng = use_model ? m_rng : hr;
        e.low = use_model ? m_low : hl;
        e.name = name;
        exp_q.push_back(e);
        drive_chk = 1'b1;
        @(negedge general_clk);
    endtask

    task automatic drain();
        int k;
        k = 0;
        drive_chk = 1'b0;
        drive(32768, 16384, 0, 2);
        while (exp_q.size() != 0 && k < 10) begin
            @(negedge general_clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic single(input int fl, input int fh, input int s, input int ns,
                          input longint hr, input longint hl, input string name);
        do_reset();
        reset = 1'b0;
        issue(fl, fh, s, ns, 1'b0, hr, hl, name);
        drain();
    endtask

    typedef struct { int fl; int fh; int s; int ns; } vec_t;
    vec_t stream_v[10] = '{
        '{32768, 24576,  0,  4},
        '{16384,  4096,  2,  4},
        '{ 4096,     0,  3,  4},
        '{24576, 16384,  1,  4},
        '{32768, 30720,  0, 16},
        '{ 4096,     0,  7,  8},
        '{16384, 12288,  3,  8},
        '{ 2048,     0, 15, 16},
        '{16384,     0,  1,  2},
        '{ 8192,  4096,  5,  8}
    };

    initial begin
        reset = 1'b1;
        drive(32768, 16384, 0, 2);
        repeat (3) @(negedge general_clk);
        check("reset_rng", longint'(RANGE_OUTPUT), 32768);
        check("reset_low", longint'(LOW_OUTPUT), 0);

        single(32768, 16384,  0,  2, 65520,      0, "s0_n2");
        single(16384,     0,  1,  2, 32776,  32760, "s1_n2");
        single(32768, 32704,  0,  2, 61440,      0, "flush");
        single( 2048,     0, 15, 16, 32832, 491456, "n16_s15");
        single(32768, 30720,  0, 16, 63616,      0, "n16_s0");

        do_reset();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            issue(stream_v[i].fl, stream_v[i].fh, stream_v[i].s, stream_v[i].ns,
                  1'b1, 0, 0, $sformatf("stream%0d", i));
        end
        drain();

        // Mid-stream reset: unchecked symbols in flight, then an async reset.
        do_reset();
        reset = 1'b0;
        drive_chk = 1'b0;
        drive(32768, 16384, 0, 2);
        repeat (3) @(negedge general_clk);
        check("pre_reset_rng", longint'(RANGE_OUTPUT), 65520);
        #2 reset = 1'b1;
        #1;
        check("midreset_rng", longint'(RANGE_OUTPUT), 32768);
        check("midreset_low", longint'(LOW_OUTPUT), 0);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
